// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation codes,
// flag bit positions and small helpers that turn an op code into the
// operand-B polarity and the initial carry.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2,
    OP_SUBB = 2'd3
  } addsub_op_e;

  localparam int FLAG_W        = 4;
  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  // Subtractions add the one's complement of B
  function automatic logic op_inverts_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SUBB);
  endfunction

  // SUB supplies the +1 of two's complement itself; the carry-using ops take
  // the external carry (for SUBB a 1 means "no borrow")
  function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder. Besides the carry out it exposes the
// carry going into its top bit, so the last stage can derive signed overflow.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic carry;

  // Ripple the carry bit by bit, remembering the carry into the msb
  always_comb begin
    carry   = cin;
    msb_cin = cin;
    sum     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        msb_cin = carry;
      end
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. Stage k adds bit slice k of the operands using
// the carry registered by stage k-1; each stage register carries the full
// operands and the partially assembled sum so every beat travels with its own
// data. A single enable stalls the whole pipe when the output is blocked.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [1:0]        in_op,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

  logic             stage_valid_q [STAGES];
  logic [WIDTH-1:0] stage_a_q     [STAGES];
  logic [WIDTH-1:0] stage_b_q     [STAGES];
  logic [WIDTH-1:0] stage_sum_q   [STAGES];
  logic             stage_carry_q [STAGES];
  logic [FLAG_W-1:0] flags_q;

  logic             stage_valid_d [STAGES];
  logic [WIDTH-1:0] stage_a_d     [STAGES];
  logic [WIDTH-1:0] stage_b_d     [STAGES];
  logic [WIDTH-1:0] stage_sum_d   [STAGES];
  logic             stage_carry_d [STAGES];
  logic             last_msb_cin;
  logic [FLAG_W-1:0] flags_d;

  // One enable for the whole pipe: move whenever the output slot is free
  assign advance   = !stage_valid_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = stage_valid_q[STAGES-1];
  assign out_sum   = stage_sum_q[STAGES-1];
  assign out_flags = flags_q;

  // Turn the op code into the effective B operand and the first carry-in
  always_comb begin
    op_b   = op_inverts_b(in_op) ? ~in_b : in_b;
    op_cin = op_carry_in(in_op, in_cin);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] sum_src;
    logic             cin_src;
    logic             valid_src;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_msb_cin;

    if (k == 0) begin : g_first
      assign a_src     = in_a;
      assign b_src     = op_b;
      assign sum_src   = '0;
      assign cin_src   = op_cin;
      assign valid_src = in_valid;
    end else begin : g_rest
      assign a_src     = stage_a_q[k-1];
      assign b_src     = stage_b_q[k-1];
      assign sum_src   = stage_sum_q[k-1];
      assign cin_src   = stage_carry_q[k-1];
      assign valid_src = stage_valid_q[k-1];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (a_src[k*CHUNK +: CHUNK]),
      .b       (b_src[k*CHUNK +: CHUNK]),
      .cin     (cin_src),
      .sum     (chunk_sum),
      .cout    (chunk_cout),
      .msb_cin (chunk_msb_cin)
    );

    // Slices above k are still zero, so the new chunk can be OR-ed into place
    assign stage_sum_d[k]   = sum_src | (WIDTH'(chunk_sum) << (k * CHUNK));
    assign stage_a_d[k]     = a_src;
    assign stage_b_d[k]     = b_src;
    assign stage_carry_d[k] = chunk_cout;
    assign stage_valid_d[k] = valid_src;

    if (k == STAGES - 1) begin : g_last
      assign last_msb_cin = chunk_msb_cin;
    end
  end

  // Flags come from the completed sum leaving the last chunk adder
  always_comb begin
    flags_d                = '0;
    flags_d[FLAG_CARRY]    = stage_carry_d[STAGES-1];
    flags_d[FLAG_OVERFLOW] = last_msb_cin ^ stage_carry_d[STAGES-1];
    flags_d[FLAG_ZERO]     = (stage_sum_d[STAGES-1] == '0);
    flags_d[FLAG_NEGATIVE] = stage_sum_d[STAGES-1][WIDTH-1];
  end

  // Stage registers: flushed by reset, otherwise all shift together on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_valid_q[k] <= 1'b0;
        stage_a_q[k]     <= '0;
        stage_b_q[k]     <= '0;
        stage_sum_q[k]   <= '0;
        stage_carry_q[k] <= 1'b0;
      end
      flags_q <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_valid_q[k] <= stage_valid_d[k];
        stage_a_q[k]     <= stage_a_d[k];
        stage_b_q[k]     <= stage_b_d[k];
        stage_sum_q[k]   <= stage_sum_d[k];
        stage_carry_q[k] <= stage_carry_d[k];
      end
      flags_q <= flags_d;
    end
  end

endmodule
